fun_fpsu_merge: RTL and testbench
=================================

# fun_fpsu_merge

Parametrised retirement merger for the split-lane FP/SIMD store unit. It generalises the fixed two-half (H/L), three-port arrangement to LANES lanes and NPORTS issue ports. Lanes may complete with arbitrary skew, so the block keeps a per-port in-order queue of outstanding ops. For each op it collects every participating lane's 14-bit return code and emits one merged `ret`/`ret_en` per op, OR-combined across lanes. It sits between the per-lane FPU slices and the retire logic.

## Interface
- `LANES`, default 2: number of 68-bit SIMD lane slices per port.
- `NPORTS`, default 3: number of issue ports (u1/u3/u5).
- `DEPTH`, default 4: outstanding ops per port; power of two, at least 2.
- `RETW`, default 14: width of a return code.

- `clk`: in, 1. Clock.
- `rst`: in, 1. Asynchronous, active-low reset.
- `flush`: in, 1. Synchronous discard of all outstanding ops.
- `iss_en`: in, NPORTS. Op issued on port p this cycle.
- `iss_lmask`: in, NPORTS*LANES. Lanes participating in the issued op.
- `iss_ready`: out, NPORTS. Port queue can accept an issue.
- `lane_ret`: in, NPORTS*LANES*RETW. Per-lane return code.
- `lane_ret_en`: in, NPORTS*LANES. Lane completion strobe.
- `ret`: out, NPORTS*RETW. Merged return code, registered.
- `ret_en`: out, NPORTS. Merged return valid, one-cycle pulse.
- `err`: out, NPORTS. Sticky protocol error.
- `skew_cnt`: out, NPORTS*16. Present only with `FPSU_SKEW_STAT_EN`.

## Operation
- Each port is independent. The port queue is a circular buffer of DEPTH entries. Each entry holds `lmask`, `done[LANES]` and `acc[RETW]`.
- Issue:
  - When `iss_en[p]` is high, `iss_ready[p]` is high and `iss_lmask` is nonzero, an entry is written at the tail with `done=0` and `acc=0`.
  - An issue with a zero mask is dropped silently.
- Completion:
  - Each lane completes its ops in issue order.
  - A `lane_ret_en[p][l]` strobe is attributed to the oldest valid entry with `lmask[l]=1` and `done[l]=0`.
  - That entry's `done[l]` is set and `acc |= lane_ret`.
  - A strobe with no such entry is ignored and sets `err[p]`.
- Retire:
  - When the head entry has `done==lmask`, including completions arriving this cycle, it is popped.
  - The next-cycle outputs are `ret[p]=acc` (merged with this cycle's contributions) and `ret_en[p]=1`.
  - At most one retire per port per cycle. A completed younger entry waits for the head.
- Issue while `iss_ready[p]=0` is dropped and sets `err[p]`.
- `iss_ready[p] = (count[p] < DEPTH)`, computed from registered count only. A same-cycle retire does not bypass a full queue.
- Flush:
  - Clears all queue valid bits and pointers. `ret_en` is 0 on the next cycle.
  - Flush beats same-cycle issue, completion and retire.
  - `err` is not cleared by flush.
- `err` clears only on reset.
- Reset values:
  - `ret=0`, `ret_en=0`, `err=0`, `skew_cnt=0`.
  - `iss_ready` is all ones (queues empty).
  - Reset asserted mid-operation discards all entries immediately.

## Timing
- Issue at cycle t: the entry is eligible for completions from t+1. A completion strobe in cycle t cannot target an op issued in cycle t.
- Last lane completion of the head at cycle t gives `ret_en` at t+1, so retire latency is 1 cycle.
- Back-to-back retires are possible every cycle per port.
- `iss_ready` deasserts the cycle after the DEPTH-th outstanding issue. It reasserts the cycle after a retire drops count below DEPTH.
- Pointer wrap: indices are modulo DEPTH. Count is a DEPTH+1-state counter, so full and empty are distinct.

## Configuration
- `FPSU_SKEW_STAT_EN` defined:
  - Adds `skew_cnt` per port: a 16-bit saturating counter.
  - It increments each cycle the head is valid with `done` nonzero but not equal to `lmask`.
  - It saturates at 0xFFFF, and is cleared by reset only.
- `FPSU_SKEW_STAT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `fpsu_merge_pkg` holds:
  - the `RETW` default constant;
  - the `fpsu_mrg_entry_t` struct (lmask, done, acc), parametrised via LANES localparam defaults;
  - the `FPSU_MRG_CNTW=16` constant.
- Sub-module `fpsu_merge_port` contains one port's queue, attribution, retire and stat logic. The top level is a generate loop over NPORTS plus bus slicing.

## Test plan
- LANES=2: issue port0 mask 2'b11. Lane0 ret 0x0001 at t+2, lane1 ret 0x0100 at t+5. Expect `ret_en` at t+6 with `ret=0x0101`; no pulse earlier.
- Issue ops A (mask 01) and B (mask 10). Lane1 completes B first, lane0 completes A three cycles later. Expect A retiring, then B retiring on the next cycle, in order.
- DEPTH=4: 5 consecutive issues with no completions. Expect `iss_ready=0` after the 4th issue, the 5th issue dropped, and `err[p]=1`.
- Lane completion strobe on an empty port: `err[p]=1`, no `ret_en`, other ports unaffected.
- 3 ops outstanding, `flush` pulse concurrent with a completing strobe. Expect no `ret_en`, `iss_ready=1`, and later issues behaving normally.
- With `FPSU_SKEW_STAT_EN`: lane0 done, lane1 done 10 cycles later. Expect `skew_cnt=10`. Reset mid-op gives every output 0 and `iss_ready` all ones.

Source files
------------

// File: rtl/fpsu_merge_pkg.sv
// Shared constants and types for the split-lane FP/SIMD store-unit retirement merger.
package fpsu_merge_pkg;

  localparam int FPSU_MRG_RETW  = 14;
  localparam int FPSU_MRG_LANES = 2;
  localparam int FPSU_MRG_CNTW  = 16;

  // One queue entry at the default lane count and return-code width.
  typedef struct packed {
    logic [FPSU_MRG_LANES-1:0] lmask;
    logic [FPSU_MRG_LANES-1:0] done;
    logic [FPSU_MRG_RETW-1:0]  acc;
  } fpsu_mrg_entry_t;

  function automatic logic [FPSU_MRG_CNTW-1:0] sat_inc(input logic [FPSU_MRG_CNTW-1:0] v);
    return (&v) ? v : v + FPSU_MRG_CNTW'(1);
  endfunction

endpackage

// File: rtl/fpsu_merge_port.sv
// One issue port of the retirement merger: in-order op queue, per-lane completion
// attribution, head retire and (with FPSU_SKEW_STAT_EN) the head skew counter.
module fpsu_merge_port
  import fpsu_merge_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int RETW  = FPSU_MRG_RETW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  iss_en,
  input  logic [LANES-1:0]      iss_lmask,
  output logic                  iss_ready,
  input  logic [LANES*RETW-1:0] lane_ret,
  input  logic [LANES-1:0]      lane_ret_en,
  output logic [RETW-1:0]       ret,
  output logic                  ret_en,
  output logic                  err
`ifdef FPSU_SKEW_STAT_EN
  ,
  output logic [FPSU_MRG_CNTW-1:0] skew_cnt
`endif
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef struct packed {
    logic [LANES-1:0] lmask;
    logic [LANES-1:0] done;
    logic [RETW-1:0]  acc;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           q_nxt [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [CNTW-1:0]  count;

  logic [PTRW-1:0]  age_idx [DEPTH];
  logic [LANES-1:0] lane_hit;
  logic             retire;
  logic             do_issue;
  logic             proto_err;

  assign iss_ready = (count < CNTW'(DEPTH));

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k] = head + PTRW'(k);
    end
  end

  // Each lane strobe lands on the oldest valid entry still waiting on that lane.
  always_comb begin
    q_nxt    = q;
    lane_hit = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (lane_ret_en[l] && !lane_hit[l] && vld[age_idx[k]] &&
            q[age_idx[k]].lmask[l] && !q[age_idx[k]].done[l]) begin
          lane_hit[l]                 = 1'b1;
          q_nxt[age_idx[k]].done[l]   = 1'b1;
          q_nxt[age_idx[k]].acc       = q_nxt[age_idx[k]].acc | lane_ret[l*RETW +: RETW];
        end
      end
    end
  end

  always_comb begin
    retire    = !flush && vld[head] && (q_nxt[head].done == q[head].lmask);
    do_issue  = !flush && iss_en && iss_ready && (|iss_lmask);
    proto_err = !flush && ((iss_en && !iss_ready) || (|(lane_ret_en & ~lane_hit)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      vld    <= '0;
      ret    <= '0;
      ret_en <= 1'b0;
      err    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        q[k] <= '0;
      end
    end else begin
      ret_en <= retire;
      if (retire) begin
        ret <= q_nxt[head].acc;
      end
      if (proto_err) begin
        err <= 1'b1;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        vld   <= '0;
      end else begin
        q <= q_nxt;
        if (retire) begin
          vld[head] <= 1'b0;
          head      <= head + PTRW'(1);
        end
        // A non-full queue never has tail aliasing a valid head, so both writes are safe.
        if (do_issue) begin
          vld[tail]     <= 1'b1;
          q[tail].lmask <= iss_lmask;
          q[tail].done  <= '0;
          q[tail].acc   <= '0;
          tail          <= tail + PTRW'(1);
        end
        count <= count + CNTW'(do_issue) - CNTW'(retire);
      end
    end
  end

`ifdef FPSU_SKEW_STAT_EN
  logic head_partial;

  assign head_partial = vld[head] && (|q[head].done) && (q[head].done != q[head].lmask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skew_cnt <= '0;
    end else if (head_partial) begin
      skew_cnt <= sat_inc(skew_cnt);
    end
  end
`endif

endmodule

// File: rtl/fun_fpsu_merge.sv
// Retirement merger for the split-lane FP/SIMD store unit: one fpsu_merge_port per issue port.
// Optional per-port head skew statistics are enabled with FPSU_SKEW_STAT_EN.
module fun_fpsu_merge
  import fpsu_merge_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int NPORTS = 3,
  parameter int DEPTH  = 4,
  parameter int RETW   = FPSU_MRG_RETW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NPORTS-1:0]            iss_en,
  input  logic [NPORTS*LANES-1:0]      iss_lmask,
  output logic [NPORTS-1:0]            iss_ready,
  input  logic [NPORTS*LANES*RETW-1:0] lane_ret,
  input  logic [NPORTS*LANES-1:0]      lane_ret_en,
  output logic [NPORTS*RETW-1:0]       ret,
  output logic [NPORTS-1:0]            ret_en,
  output logic [NPORTS-1:0]            err
`ifdef FPSU_SKEW_STAT_EN
  ,
  output logic [NPORTS*FPSU_MRG_CNTW-1:0] skew_cnt
`endif
);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fpsu_merge_port #(
      .LANES (LANES),
      .DEPTH (DEPTH),
      .RETW  (RETW)
    ) u_port (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .iss_en      (iss_en[p]),
      .iss_lmask   (iss_lmask[p*LANES +: LANES]),
      .iss_ready   (iss_ready[p]),
      .lane_ret    (lane_ret[p*LANES*RETW +: LANES*RETW]),
      .lane_ret_en (lane_ret_en[p*LANES +: LANES]),
      .ret         (ret[p*RETW +: RETW]),
      .ret_en      (ret_en[p]),
      .err         (err[p])
`ifdef FPSU_SKEW_STAT_EN
      ,
      .skew_cnt    (skew_cnt[p*FPSU_MRG_CNTW +: FPSU_MRG_CNTW])
`endif
    );
  end

endmodule

// File: tb/tb_fun_fpsu_merge.sv
// Scoreboard bench for fun_fpsu_merge: op-level queue model drives expectations,
// a posedge monitor compares ret/ret_en/iss_ready/err (and skew_cnt with FPSU_SKEW_STAT_EN).
module tb_fun_fpsu_merge;

  localparam int LANES  = 2;
  localparam int NPORTS = 3;
  localparam int DEPTH  = 4;
  localparam int RETW   = 14;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic                         flush;
  logic [NPORTS-1:0]            iss_en;
  logic [NPORTS*LANES-1:0]      iss_lmask;
  logic [NPORTS-1:0]            iss_ready;
  logic [NPORTS*LANES*RETW-1:0] lane_ret;
  logic [NPORTS*LANES-1:0]      lane_ret_en;
  logic [NPORTS*RETW-1:0]       ret;
  logic [NPORTS-1:0]            ret_en;
  logic [NPORTS-1:0]            err;
`ifdef FPSU_SKEW_STAT_EN
  logic [NPORTS*16-1:0]         skew_cnt;
`endif

  always #5 clk = ~clk;

  fun_fpsu_merge #(
    .LANES  (LANES),
    .NPORTS (NPORTS),
    .DEPTH  (DEPTH),
    .RETW   (RETW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .iss_en      (iss_en),
    .iss_lmask   (iss_lmask),
    .iss_ready   (iss_ready),
    .lane_ret    (lane_ret),
    .lane_ret_en (lane_ret_en),
    .ret         (ret),
    .ret_en      (ret_en),
    .err         (err)
`ifdef FPSU_SKEW_STAT_EN
    ,
    .skew_cnt    (skew_cnt)
`endif
  );

  typedef struct {
    logic [LANES-1:0] lmask;
    logic [LANES-1:0] done;
    logic [RETW-1:0]  acc;
  } op_t;

  op_t              mq    [NPORTS][$];
  logic [RETW-1:0]  exp_q [NPORTS][$];
  logic [NPORTS-1:0] exp_err;
  int               exp_skew [NPORTS];
  int               checks = 0;
  int               errors = 0;
  bit               mon_en = 1'b0;

  task automatic checkOutput(input string name, input int p, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s port%0d: got 0x%0h expected 0x%0h at %0t", name, p, act, expv, $time);
    end
  endtask

  function automatic bit lane_pending(input int p, input int l);
    for (int i = 0; i < mq[p].size(); i++) begin
      if (mq[p][i].lmask[l] && !mq[p][i].done[l]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Op-level model: lanes finish in issue order, head retires once every lane reported.
  task automatic model_step();
    for (int p = 0; p < NPORTS; p++) begin
      int  n_before;
      bit  found;
      op_t o;
      n_before = mq[p].size();
      if (n_before > 0 && mq[p][0].done != '0 && mq[p][0].done != mq[p][0].lmask &&
          exp_skew[p] < 65535)
        exp_skew[p]++;
      if (flush) begin
        mq[p].delete();
      end else begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_ret_en[p*LANES+l]) begin
            found = 1'b0;
            for (int i = 0; i < mq[p].size(); i++) begin
              if (!found && mq[p][i].lmask[l] && !mq[p][i].done[l]) begin
                found     = 1'b1;
                o         = mq[p][i];
                o.done[l] = 1'b1;
                o.acc     = o.acc | lane_ret[(p*LANES+l)*RETW +: RETW];
                mq[p][i]  = o;
              end
            end
            if (!found) exp_err[p] = 1'b1;
          end
        end
        if (mq[p].size() > 0 && mq[p][0].done == mq[p][0].lmask) begin
          exp_q[p].push_back(mq[p][0].acc);
          void'(mq[p].pop_front());
        end
        if (iss_en[p]) begin
          if (n_before < DEPTH) begin
            if (iss_lmask[p*LANES +: LANES] != '0) begin
              o.lmask = iss_lmask[p*LANES +: LANES];
              o.done  = '0;
              o.acc   = '0;
              mq[p].push_back(o);
            end
          end else begin
            exp_err[p] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    flush       = 1'b0;
    iss_en      = '0;
    iss_lmask   = '0;
    lane_ret    = '0;
    lane_ret_en = '0;
  endtask

  // Called at a negedge with this cycle's inputs already driven.
  task automatic applyStimulus();
    model_step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic set_issue(input int p, input logic [LANES-1:0] m);
    iss_en[p]                  = 1'b1;
    iss_lmask[p*LANES +: LANES] = m;
  endtask

  task automatic set_strobe(input int p, input int l, input logic [RETW-1:0] v);
    lane_ret_en[p*LANES+l]             = 1'b1;
    lane_ret[(p*LANES+l)*RETW +: RETW] = v;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NPORTS; p++) begin
      mq[p].delete();
      exp_q[p].delete();
      exp_skew[p] = 0;
    end
    exp_err = '0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int p = 0; p < NPORTS; p++) begin
      checkOutput({tag, "_ret"}, p, 32'(ret[p*RETW +: RETW]), 32'd0);
      checkOutput({tag, "_ret_en"}, p, 32'(ret_en[p]), 32'd0);
      checkOutput({tag, "_err"}, p, 32'(err[p]), 32'd0);
      checkOutput({tag, "_iss_ready"}, p, 32'(iss_ready[p]), 32'd1);
`ifdef FPSU_SKEW_STAT_EN
      checkOutput({tag, "_skew"}, p, 32'(skew_cnt[p*16 +: 16]), 32'd0);
`endif
    end
  endtask

  // Monitor: one sample per cycle, just after the active edge.
  initial begin
    logic [RETW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        for (int p = 0; p < NPORTS; p++) begin
          checkOutput("ret_en", p, 32'(ret_en[p]), 32'(exp_q[p].size() != 0));
          if (exp_q[p].size() != 0) begin
            e = exp_q[p].pop_front();
            if (ret_en[p]) checkOutput("ret", p, 32'(ret[p*RETW +: RETW]), 32'(e));
          end
          checkOutput("iss_ready", p, 32'(iss_ready[p]), 32'(mq[p].size() < DEPTH));
          checkOutput("err", p, 32'(err[p]), 32'(exp_err[p]));
`ifdef FPSU_SKEW_STAT_EN
          checkOutput("skew_cnt", p, 32'(skew_cnt[p*16 +: 16]), 32'(exp_skew[p]));
`endif
        end
      end
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst    = 1'b1;
    mon_en = 1'b1;

    // Two-lane op, lanes report with skew, single merged pulse.
    set_issue(0, 2'b11);           applyStimulus();
    idle(1);
    set_strobe(0, 0, 14'h0001);    applyStimulus();
    idle(2);
    set_strobe(0, 1, 14'h0100);    applyStimulus();
    idle(3);

    // Younger op completes first but waits for the head.
    set_issue(0, 2'b01);           applyStimulus();
    set_issue(0, 2'b10);           applyStimulus();
    idle(1);
    set_strobe(0, 1, 14'h0020);    applyStimulus();
    idle(2);
    set_strobe(0, 0, 14'h0004);    applyStimulus();
    idle(3);

    // Overfill port 1.
    for (int i = 0; i < 5; i++) begin
      set_issue(1, 2'b11);
      applyStimulus();
    end
    idle(2);

    // Stray strobe on empty port 2.
    set_strobe(2, 0, 14'h3fff);    applyStimulus();
    idle(2);

    // Flush with a completing strobe in the same cycle.
    for (int i = 0; i < 3; i++) begin
      set_issue(0, 2'b01);
      applyStimulus();
    end
    flush = 1'b1;
    set_strobe(0, 0, 14'h0008);    applyStimulus();
    idle(1);
    set_issue(0, 2'b11);           applyStimulus();
    set_strobe(0, 0, 14'h0010);
    set_strobe(0, 1, 14'h0200);    applyStimulus();
    idle(2);

    // Reset asserted while ops are outstanding.
    set_issue(0, 2'b11);
    set_issue(2, 2'b01);           applyStimulus();
    set_strobe(0, 0, 14'h0002);    applyStimulus();
    rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

`ifdef FPSU_SKEW_STAT_EN
    set_issue(0, 2'b11);           applyStimulus();
    set_strobe(0, 0, 14'h0040);    applyStimulus();
    idle(9);
    set_strobe(0, 1, 14'h0080);    applyStimulus();
    checkOutput("skew_directed", 0, 32'(skew_cnt[15:0]), 32'd10);
    idle(2);
`endif

    // Random legal traffic with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(79) == 0);
      for (int p = 0; p < NPORTS; p++) begin
        if (mq[p].size() < DEPTH && $urandom_range(2) == 0)
          set_issue(p, LANES'($urandom));
        for (int l = 0; l < LANES; l++) begin
          if (lane_pending(p, l) && $urandom_range(1) == 0)
            set_strobe(p, l, RETW'($urandom));
        end
      end
      applyStimulus();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
